mulu_int: RTL and testbench

//   Sequential radix-2 shift-add integer multiplier for the ALU module.
//   It is the multiply counterpart of the iterative divider and uses the same start/busy/done/valid handshake.
//   It computes a full 2*WIDTH product, unsigned or two's-complement signed, one partial product per cycle.
//   The ALU takes val for MUL and hi for MULH.

---
 rtl/mulu_int_pkg.sv | 10 +
 rtl/mulu_int.sv | 138 +++++++++++++
 tb/tb_mulu_int.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mulu_int_pkg.sv
// Shared definitions for the shift-add integer multiplier: FSM state encoding.
package mulu_int_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_SIGN = 2'b10
  } mul_state_t;

endpackage

// File: rtl/mulu_int.sv
// Sequential radix-2 shift-add multiplier producing a full 2*WIDTH product,
// signed or unsigned, one partial product per clock with start/busy/done/valid handshake.
module mulu_int
  import mulu_int_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CBITS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             ovf,
  output logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] hi
);

  mul_state_t           state_r;
  logic [WIDTH-1:0]     mcand_r;
  logic [WIDTH-1:0]     mult_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [CBITS-1:0]     count_r;
  logic                 neg_r;
  logic                 sgn_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 valid_r;
  logic                 ovf_r;
  logic [WIDTH-1:0]     val_r;
  logic [WIDTH-1:0]     hi_r;

  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH:0]       top_s;
  logic                 ovf_s;

  // Magnitude of an operand; a signed MIN maps onto 1<<(WIDTH-1), still exact in WIDTH bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic s);
    if (s && x[WIDTH-1]) begin
      return (~x) + WIDTH'(1'b1);
    end else begin
      return x;
    end
  endfunction

  // Partial-product adder, sign correction of the product and overflow detection.
  always_comb begin
    sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (mult_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    prod_s = acc_r;
    if (neg_r) begin
      prod_s = (~acc_r) + (2*WIDTH)'(1'b1);
    end else begin
      prod_s = acc_r;
    end
    top_s = prod_s[2*WIDTH-1:WIDTH-1];
    if (sgn_r) begin
      ovf_s = !((&top_s) || !(|top_s));
    end else begin
      ovf_s = |prod_s[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM plus datapath registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      mcand_r <= '0;
      mult_r  <= '0;
      acc_r   <= '0;
      count_r <= '0;
      neg_r   <= 1'b0;
      sgn_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
      val_r   <= '0;
      hi_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            mcand_r <= magnitude(a, sgn);
            mult_r  <= magnitude(b, sgn);
            neg_r   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            sgn_r   <= sgn;
            acc_r   <= '0;
            count_r <= '0;
            busy_r  <= 1'b1;
            valid_r <= 1'b0;
            state_r <= ST_CALC;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          // Carry out of the adder becomes the new MSB as {carry,acc} shifts right.
          acc_r   <= {sum_s, acc_r[WIDTH-1:1]};
          mult_r  <= {1'b0, mult_r[WIDTH-1:1]};
          count_r <= count_r + CBITS'(1'b1);
          if (count_r == CBITS'(WIDTH-1)) begin
            state_r <= ST_SIGN;
          end else begin
            state_r <= ST_CALC;
          end
        end
        ST_SIGN: begin
          val_r   <= prod_s[WIDTH-1:0];
          hi_r    <= prod_s[2*WIDTH-1:WIDTH];
          ovf_r   <= ovf_s;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          valid_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign valid = valid_r;
  assign ovf   = ovf_r;
  assign val   = val_r;
  assign hi    = hi_r;

endmodule

// File: tb/tb_mulu_int.sv
// Scoreboard bench for mulu_int: stimulus pushes model results, a monitor checks each done pulse.
module tb_mulu_int;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sgn = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, valid, ovf;
  logic [W-1:0] val, hi;

  typedef struct {
    logic [W-1:0] val;
    logic [W-1:0] hi;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic [W-1:0] last_val, last_hi;

  mulu_int #(.WIDTH(W), .CBITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .valid(valid), .ovf(ovf), .val(val), .hi(hi)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Behavioural reference: plain arithmetic on 64-bit integers.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t e;
    longint p;
    logic [63:0] u;
    if (s) begin
      p = longint'($signed(x)) * longint'($signed(y));
      e.ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      u = p;
    end else begin
      u = {32'd0, x} * {32'd0, y};
      e.ovf = (u > 64'd4294967295);
    end
    e.val = u[31:0];
    e.hi  = u[63:32];
    e.due = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_done) check("done_one_cycle", {63'd0, done}, 64'd0);
        if (done) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: got done=1 expected no pending result at cycle %0d", cyc);
          end else begin
            e = q.pop_front();
            check("val",     {32'd0, val}, {32'd0, e.val});
            check("hi",      {32'd0, hi},  {32'd0, e.hi});
            check("ovf",     {63'd0, ovf}, {63'd0, e.ovf});
            check("valid",   {63'd0, valid}, 64'd1);
            check("busy_lo", {63'd0, busy}, 64'd0);
            check("latency", 64'(cyc), 64'(e.due));
            last_val = e.val;
            last_hi  = e.hi;
          end
        end
      end
      prev_done = done;
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t e;
    @(negedge clk);
    a = x; b = y; sgn = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = model(x, y, s);
    e.due = cyc + W + 1;
    q.push_back(e);
    check("accept_busy",  {63'd0, busy},  64'd1);
    check("accept_valid", {63'd0, valid}, 64'd0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: got %0d results pending expected 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] x, y;
    exp_t e;
    #2;
    check("rst_busy",  {63'd0, busy},  64'd0);
    check("rst_done",  {63'd0, done},  64'd0);
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_ovf",   {63'd0, ovf},   64'd0);
    check("rst_val",   {32'd0, val},   64'd0);
    check("rst_hi",    {32'd0, hi},    64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(32'd100000000, 32'd3, 1'b0);                wait_idle();
    check("hold_val", {32'd0, val}, {32'd0, last_val});
    check("hold_valid", {63'd0, valid}, 64'd1);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);          wait_idle();
    issue(-32'sd7, 32'd6, 1'b1);                      wait_idle();
    issue(-32'sd7, 32'd6, 1'b0);                      wait_idle();
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1);          wait_idle();
    issue(32'h80000000, 32'h80000000, 1'b1);          wait_idle();
    issue(32'd166, 32'd0, 1'b0);                      wait_idle();
    issue(32'd0, 32'hDEADBEEF, 1'b1);                 wait_idle();

    // Start pulse while busy must be ignored.
    issue(32'h12345678, 32'h9ABCDEF0, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    a = 32'h0000FFFF; b = 32'h00000011; sgn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Start held high: back-to-back operations.
    @(negedge clk);
    a = 32'd12345; b = 32'd678; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    e = model(32'd12345, 32'd678, 1'b0); e.due = cyc + W + 1; q.push_back(e);
    a = 32'hFFFF0000; b = 32'h7FFFFFFF; sgn = 1'b1;
    e = model(32'hFFFF0000, 32'h7FFFFFFF, 1'b1); e.due = cyc + 2*W + 3; q.push_back(e);
    repeat (W + 2) @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", {63'd0, busy}, 64'd1);
    wait_idle();

    // Asynchronous reset in the middle of CALC.
    issue(32'hCAFEBABE, 32'h00C0FFEE, 1'b0);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("arst_busy",  {63'd0, busy},  64'd0);
    check("arst_valid", {63'd0, valid}, 64'd0);
    check("arst_done",  {63'd0, done},  64'd0);
    check("arst_val",   {32'd0, val},   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    issue(32'hCAFEBABE, 32'h00C0FFEE, 1'b0);          wait_idle();

    // Randomized operands with corner-value bias.
    for (int i = 0; i < 40; i++) begin
      x = $urandom();
      y = $urandom();
      case ($urandom_range(0, 7))
        0: x = 32'h80000000;
        1: y = 32'hFFFFFFFF;
        2: x = 32'd0;
        3: y = 32'h7FFFFFFF;
        default: ;
      endcase
      issue(x, y, 1'($urandom_range(0, 1)));
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
